// File: rtl/debug_unit_pkg.sv
// Shared constants for the host debug controller: command bytes, program
// terminator, dump layout and FSM state encoding.
package debug_unit_pkg;

    localparam logic [7:0]  CMD_LOAD          = 8'h4C;  // 'L'
    localparam logic [7:0]  CMD_RUN           = 8'h52;  // 'R'
    localparam logic [7:0]  CMD_STEP          = 8'h53;  // 'S'

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Dump header: cycle count followed by PC, then registers, then memory.
    localparam int          DUMP_HDR_WORDS    = 2;
    localparam int          BYTES_PER_WORD    = 4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD_RX   = 4'd1,
        ST_LOAD_WR   = 4'd2,
        ST_RUN       = 4'd3,
        ST_STEP      = 4'd4,
        ST_DUMP_LOAD = 4'd5,
        ST_MEM_WAIT  = 4'd6,
        ST_TX_START  = 4'd7,
        ST_TX_WAIT   = 4'd8
    } state_e;

endpackage

// File: rtl/debug_unit_tx.sv
// Word-to-byte serializer: sends one word MSB first over the UART
// tx_start/tx_done handshake, with at most one byte outstanding.
module debug_tx_serializer #(
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] word,
    input  logic                 tx_done,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic                 done
);

    localparam int N_BYTES = WORD_BITS / 8;
    localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

    logic [WORD_BITS-1:0] shift_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r;
    logic [7:0]           tx_data_r;
    logic                 tx_start_r;
    logic                 done_r;

    // Byte sequencing: launch first byte on start, next byte on each tx_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= {WORD_BITS{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            done_r     <= 1'b0;
            if (!busy_r) begin
                if (start) begin
                    tx_data_r  <= word[WORD_BITS-1 -: 8];
                    shift_r    <= {word[WORD_BITS-9:0], 8'h00};
                    cnt_r      <= {CNT_W{1'b0}};
                    busy_r     <= 1'b1;
                    tx_start_r <= 1'b1;
                end
            end else if (tx_done) begin
                // tx_done is only meaningful while a byte is in flight.
                if (cnt_r == LAST_BYTE) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    tx_data_r  <= shift_r[WORD_BITS-1 -: 8];
                    shift_r    <= {shift_r[WORD_BITS-9:0], 8'h00};
                    cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    tx_start_r <= 1'b1;
                end
            end
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign done     = done_r;

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: loads program words from the UART, gates the
// datapath for RUN/STEP and streams processor state back to the host.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int PROC_BITS        = 32,
    parameter int DATA_ADDRS_BITS  = 7,
    parameter int N_REGS           = 32,
    parameter int DUMP_MEM_WORDS   = 32,
    parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_done,
    input  logic                        i_tx_done,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_start,
    input  logic                        i_halt,
    input  logic [PC_BITS-1:0]          i_pc,
    input  logic [N_REGS*PROC_BITS-1:0] i_rf_regs,
    input  logic [PROC_BITS-1:0]        i_mem_data,
    output logic                        o_enable,
    output logic                        o_write_inst_mem,
    output logic [PC_BITS-1:0]          o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                        o_debug_read_data,
    output logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address
);

    localparam int DUMP_WORDS = DUMP_HDR_WORDS + N_REGS + DUMP_MEM_WORDS;
    localparam int IDX_W      = $clog2(DUMP_WORDS);
    localparam int REG_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [IDX_W-1:0] IDX_CYC  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_PC   = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_BASE = IDX_W'(DUMP_HDR_WORDS);
    localparam logic [IDX_W-1:0] MEM_BASE = IDX_W'(DUMP_HDR_WORDS + N_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);

    state_e                      state_r, state_s;
    logic [PC_BITS-1:0]          load_addr_r, load_addr_s;
    logic [INSTRUCTION_BITS-1:0] word_r, word_s, word_next_s;
    logic [1:0]                  byte_cnt_r, byte_cnt_s;
    logic [PROC_BITS-1:0]        cycle_cnt_r, cycle_cnt_s;
    logic [IDX_W-1:0]            dump_idx_r, dump_idx_s;
    logic                        enable_r, enable_s;
    logic                        wr_r, wr_s;
    logic [PC_BITS-1:0]          inst_addr_r, inst_addr_s;
    logic [INSTRUCTION_BITS-1:0] inst_data_r, inst_data_s;
    logic                        rd_r, rd_s;
    logic [DATA_ADDRS_BITS-1:0]  rd_addr_r, rd_addr_s;

    logic                        ser_start_s;
    logic                        ser_done_s;
    logic [PROC_BITS-1:0]        dump_word_s;
    logic [PROC_BITS-1:0]        rf_s [N_REGS];
    logic [REG_W-1:0]            reg_sel_s;
    logic [DATA_ADDRS_BITS-1:0]  mem_sel_s;

    for (genvar k = 0; k < N_REGS; k++) begin : g_rf
        assign rf_s[k] = i_rf_regs[k*PROC_BITS +: PROC_BITS];
    end

    assign word_next_s = {word_r[INSTRUCTION_BITS-9:0], i_rx_data};

    // Select the word for the current dump slot; sampled on its first send.
    always_comb begin
        reg_sel_s = REG_W'(dump_idx_r - REG_BASE);
        mem_sel_s = DATA_ADDRS_BITS'(dump_idx_r - MEM_BASE);
        if (dump_idx_r == IDX_CYC) begin
            dump_word_s = cycle_cnt_r;
        end else if (dump_idx_r == IDX_PC) begin
            dump_word_s = PROC_BITS'(i_pc);
        end else if (dump_idx_r < MEM_BASE) begin
            dump_word_s = rf_s[reg_sel_s];
        end else begin
            dump_word_s = i_mem_data;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s     = state_r;
        load_addr_s = load_addr_r;
        word_s      = word_r;
        byte_cnt_s  = byte_cnt_r;
        cycle_cnt_s = cycle_cnt_r + {{(PROC_BITS-1){1'b0}}, enable_r};
        dump_idx_s  = dump_idx_r;
        enable_s    = enable_r;
        wr_s        = 1'b0;
        inst_addr_s = inst_addr_r;
        inst_data_s = inst_data_r;
        rd_s        = rd_r;
        rd_addr_s   = rd_addr_r;
        ser_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_rx_done) begin
                    dump_idx_s = {IDX_W{1'b0}};
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_s     = ST_LOAD_RX;
                            load_addr_s = {PC_BITS{1'b0}};
                            cycle_cnt_s = {PROC_BITS{1'b0}};
                            byte_cnt_s  = 2'd0;
                        end
                        CMD_RUN, CMD_STEP: begin
                            // A halted core is never stepped; go straight to dump.
                            if (i_halt) begin
                                state_s = ST_DUMP_LOAD;
                            end else begin
                                state_s  = (i_rx_data == CMD_RUN) ? ST_RUN : ST_STEP;
                                enable_s = 1'b1;
                            end
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_RX: begin
                if (i_rx_done) begin
                    word_s = word_next_s;
                    if (byte_cnt_r == 2'd3) begin
                        state_s     = ST_LOAD_WR;
                        wr_s        = 1'b1;
                        inst_addr_s = load_addr_r;
                        inst_data_s = word_next_s;
                        byte_cnt_s  = 2'd0;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 2'd1;
                    end
                end else begin
                    state_s = ST_LOAD_RX;
                end
            end
            ST_LOAD_WR: begin
                load_addr_s = load_addr_r + {{(PC_BITS-1){1'b0}}, 1'b1};
                if (inst_data_r == HALT_WORD) begin
                    state_s    = ST_IDLE;
                    byte_cnt_s = 2'd0;
                end else begin
                    state_s = ST_LOAD_RX;
                    // A byte arriving during the write starts the next word.
                    if (i_rx_done) begin
                        word_s     = word_next_s;
                        byte_cnt_s = 2'd1;
                    end else begin
                        byte_cnt_s = 2'd0;
                    end
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    enable_s = 1'b0;
                    state_s  = ST_DUMP_LOAD;
                end else begin
                    enable_s = 1'b1;
                end
            end
            ST_STEP: begin
                enable_s = 1'b0;
                state_s  = ST_DUMP_LOAD;
            end
            ST_DUMP_LOAD: begin
                if (dump_idx_r >= MEM_BASE) begin
                    rd_s      = 1'b1;
                    rd_addr_s = mem_sel_s;
                    state_s   = ST_MEM_WAIT;
                end else begin
                    state_s = ST_TX_START;
                end
            end
            ST_MEM_WAIT: begin
                state_s = ST_TX_START;
            end
            ST_TX_START: begin
                ser_start_s = 1'b1;
                state_s     = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (ser_done_s) begin
                    if (dump_idx_r == LAST_IDX) begin
                        state_s   = ST_IDLE;
                        rd_s      = 1'b0;
                        rd_addr_s = {DATA_ADDRS_BITS{1'b0}};
                    end else begin
                        state_s    = ST_DUMP_LOAD;
                        dump_idx_s = dump_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_TX_WAIT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                enable_s = 1'b0;
                rd_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            load_addr_r <= {PC_BITS{1'b0}};
            word_r      <= {INSTRUCTION_BITS{1'b0}};
            byte_cnt_r  <= 2'd0;
            cycle_cnt_r <= {PROC_BITS{1'b0}};
            dump_idx_r  <= {IDX_W{1'b0}};
            enable_r    <= 1'b0;
            wr_r        <= 1'b0;
            inst_addr_r <= {PC_BITS{1'b0}};
            inst_data_r <= {INSTRUCTION_BITS{1'b0}};
            rd_r        <= 1'b0;
            rd_addr_r   <= {DATA_ADDRS_BITS{1'b0}};
        end else begin
            state_r     <= state_s;
            load_addr_r <= load_addr_s;
            word_r      <= word_s;
            byte_cnt_r  <= byte_cnt_s;
            cycle_cnt_r <= cycle_cnt_s;
            dump_idx_r  <= dump_idx_s;
            enable_r    <= enable_s;
            wr_r        <= wr_s;
            inst_addr_r <= inst_addr_s;
            inst_data_r <= inst_data_s;
            rd_r        <= rd_s;
            rd_addr_r   <= rd_addr_s;
        end
    end

    debug_tx_serializer #(.WORD_BITS(PROC_BITS)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (ser_start_s),
        .word     (dump_word_s),
        .tx_done  (i_tx_done),
        .tx_data  (o_tx_data),
        .tx_start (o_tx_start),
        .done     (ser_done_s)
    );

    assign o_enable             = enable_r;
    assign o_write_inst_mem     = wr_r;
    assign o_inst_mem_addr      = inst_addr_r;
    assign o_inst_mem_data      = inst_data_r;
    assign o_debug_read_data    = rd_r;
    assign o_debug_read_address = rd_addr_r;

endmodule

// File: tb/tb_debug_unit.sv
// Directed self-checking bench for debug_unit: load, step, run, reset abort.
module tb_debug_unit;
    import debug_unit_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    i_rx_data;
    logic          i_rx_done;
    logic          i_tx_done;
    logic [7:0]    o_tx_data;
    logic          o_tx_start;
    logic          i_halt;
    logic [31:0]   i_pc;
    logic [1023:0] i_rf_regs;
    logic [31:0]   i_mem_data;
    logic          o_enable;
    logic          o_write_inst_mem;
    logic [31:0]   o_inst_mem_addr;
    logic [31:0]   o_inst_mem_data;
    logic          o_debug_read_data;
    logic [6:0]    o_debug_read_address;

    logic [31:0] tb_pc;
    logic [31:0] tb_regs [32];
    logic [31:0] tb_mem [128];
    logic [31:0] mem_pend;
    logic [7:0]  tx_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic        outstanding;
    logic        halt_force;
    int          dly;
    int          viol;
    int          en_cnt;
    int          en_base;
    int          halt_at;
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    assign i_pc   = tb_pc;
    assign i_halt = halt_force | ((halt_at != 0) && ((en_cnt - en_base) >= halt_at));
    for (genvar k = 0; k < 32; k++) begin : g_rf
        assign i_rf_regs[k*32 +: 32] = tb_regs[k];
    end

    debug_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_rx_data            (i_rx_data),
        .i_rx_done            (i_rx_done),
        .i_tx_done            (i_tx_done),
        .o_tx_data            (o_tx_data),
        .o_tx_start           (o_tx_start),
        .i_halt               (i_halt),
        .i_pc                 (i_pc),
        .i_rf_regs            (i_rf_regs),
        .i_mem_data           (i_mem_data),
        .o_enable             (o_enable),
        .o_write_inst_mem     (o_write_inst_mem),
        .o_inst_mem_addr      (o_inst_mem_addr),
        .o_inst_mem_data      (o_inst_mem_data),
        .o_debug_read_data    (o_debug_read_data),
        .o_debug_read_address (o_debug_read_address)
    );

    // Environment: UART TX responder, one-cycle-latency data memory, monitors.
    initial begin
        i_tx_done = 1'b0; i_mem_data = 32'h0; mem_pend = 32'h0;
        outstanding = 1'b0; dly = 0; viol = 0; en_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (o_enable) en_cnt++;
            if (o_write_inst_mem) begin
                wr_addr_q.push_back(o_inst_mem_addr);
                wr_data_q.push_back(o_inst_mem_data);
            end
            i_mem_data = mem_pend;
            mem_pend   = o_debug_read_data ? tb_mem[o_debug_read_address] : 32'h0;
            i_tx_done  = 1'b0;
            if (rst) begin
                outstanding = 1'b0;
            end else if (o_tx_start) begin
                if (outstanding) viol++;
                outstanding = 1'b1;
                tx_q.push_back(o_tx_data);
                dly = 2;
            end else if (outstanding) begin
                if (dly == 0) begin
                    i_tx_done   = 1'b1;
                    outstanding = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] outs_vec();
        return {13'h0, o_tx_data, o_tx_start, o_enable, o_write_inst_mem, o_inst_mem_addr,
                o_inst_mem_data, o_debug_read_data, o_debug_read_address};
    endfunction

    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] cyc);
        logic [31:0] w;
        int wi;
        wi = i / 4;
        if (wi == 0)      w = cyc;
        else if (wi == 1) w = tb_pc;
        else if (wi < 34) w = tb_regs[wi-2];
        else              w = tb_mem[wi-34];
        return w[31-8*(i%4) -: 8];
    endfunction

    function automatic logic [31:0] qword(input int off);
        if (off + 3 >= tx_q.size()) return 32'hXXXX_XXXX;
        return {tx_q[off], tx_q[off+1], tx_q[off+2], tx_q[off+3]};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
    endtask

    task automatic rx_quiet();
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic load_halt_only();
        send(CMD_LOAD);
        repeat (4) send(8'hFF);
        rx_quiet();
        repeat (4) @(negedge clk);
    endtask

    task automatic run_dump(input string tag, input logic [7:0] cmd, input logic [31:0] cyc_exp,
                            input int en_exp, output int base);
        int mism;
        int vbase;
        base = tx_q.size(); en_base = en_cnt; vbase = viol; mism = 0;
        send(cmd);
        rx_quiet();
        for (int i = 0; i < 6000 && tx_q.size() < base + 264; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check_val({tag, " bytes"}, 96'(tx_q.size() - base), 96'd264);
        check_val({tag, " cycles"}, 96'(qword(base)), 96'(cyc_exp));
        check_val({tag, " pc"}, 96'(qword(base + 4)), 96'h0000_0004);
        for (int i = 0; i < 264; i++) begin
            if (base + i >= tx_q.size()) mism++;
            else if (tx_q[base+i] !== exp_byte(i, cyc_exp)) mism++;
        end
        check_val({tag, " stream"}, 96'(mism), 96'd0);
        check_val({tag, " enable"}, 96'(en_cnt - en_base), 96'(en_exp));
        check_val({tag, " handshake"}, 96'(viol - vbase), 96'd0);
        check_val({tag, " rd_sel"}, 96'(o_debug_read_data), 96'd0);
    endtask

    initial begin
        int wb;
        int tb0;
        int n;
        logic [7:0]  load_bytes [13];
        logic [31:0] exp_addr [3];
        logic [31:0] exp_data [3];
        n_tests = 0; n_fail = 0;
        rst = 1'b1; i_rx_data = 8'h00; i_rx_done = 1'b0; halt_force = 1'b0; halt_at = 0;
        tb_pc = 32'h0000_0004; en_base = 0;
        for (int k = 0; k < 32; k++) tb_regs[k] = {8'(k), 8'h5A, 8'h3C, 8'(k)};
        tb_regs[3] = 32'h0000_00A5;
        for (int k = 0; k < 128; k++) tb_mem[k] = 32'hC0DE_0000 | 32'(k);
        tb_mem[2] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        check_val("reset outs", outs_vec(), 96'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // LOAD sent back to back so a byte lands in every write cycle.
        load_bytes = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
                       8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_addr = '{32'd0, 32'd1, 32'd2};
        exp_data = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
        wb = wr_addr_q.size(); tb0 = tx_q.size();
        for (int i = 0; i < 13; i++) send(load_bytes[i]);
        rx_quiet();
        repeat (6) @(negedge clk);
        check_val("load writes", 96'(wr_addr_q.size() - wb), 96'd3);
        for (int i = 0; i < 3; i++) begin
            if (wb + i < wr_addr_q.size()) begin
                check_val("load addr", 96'(wr_addr_q[wb+i]), 96'(exp_addr[i]));
                check_val("load data", 96'(wr_data_q[wb+i]), 96'(exp_data[i]));
            end
        end
        check_val("load no tx", 96'(tx_q.size() - tb0), 96'd0);

        // STEP after load: one enable cycle, cycle count 1.
        run_dump("step", CMD_STEP, 32'd1, 1, tb0);
        check_val("step reg3", 96'(qword(tb0 + 20)), 96'h0000_00A5);
        check_val("step mem2", 96'(qword(tb0 + 144)), 96'hDEAD_BEEF);

        // RUN with halt after 10 enabled cycles, from a freshly cleared counter.
        load_halt_only();
        halt_at = 10;
        run_dump("run", CMD_RUN, 32'h0000_000A, 10, tb0);
        halt_at = 0;
        repeat (2) @(negedge clk);

        // Unknown byte ignored, then a normal STEP.
        send(8'h00);
        rx_quiet();
        repeat (3) @(negedge clk);
        run_dump("unknown+step", CMD_STEP, 32'h0000_000B, 1, tb0);

        // Halt already high: no enable, count unchanged.
        halt_force = 1'b1;
        repeat (2) @(negedge clk);
        run_dump("halted run", CMD_RUN, 32'h0000_000B, 0, tb0);
        run_dump("halted step", CMD_STEP, 32'h0000_000B, 0, tb0);
        halt_force = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after 2 bytes of the second word: no partial write.
        wb = wr_addr_q.size();
        send(CMD_LOAD);
        send(8'h00); send(8'h00); send(8'h00); send(8'h07);
        send(8'hAA); send(8'hBB);
        @(negedge clk);
        i_rx_done = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_load outs", outs_vec(), 96'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_load writes", 96'(wr_addr_q.size() - wb), 96'd1);
        send(CMD_LOAD);
        send(8'h00); send(8'h00); send(8'h00); send(8'h09);
        repeat (4) send(8'hFF);
        rx_quiet();
        repeat (6) @(negedge clk);
        check_val("reload writes", 96'(wr_addr_q.size() - wb), 96'd3);
        if (wr_addr_q.size() >= wb + 3) begin
            check_val("reload addr0", 96'(wr_addr_q[wb+1]), 96'd0);
            check_val("reload data0", 96'(wr_data_q[wb+1]), 96'h0000_0009);
            check_val("reload addr1", 96'(wr_addr_q[wb+2]), 96'd1);
        end

        // Reset in the middle of a dump.
        tb0 = tx_q.size();
        send(CMD_STEP);
        rx_quiet();
        for (int i = 0; i < 500 && tx_q.size() < tb0 + 10; i++) @(negedge clk);
        check_val("rst_dump started", 96'(tx_q.size() >= tb0 + 10), 96'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_dump outs", outs_vec(), 96'd0);
        rst = 1'b0;
        n = tx_q.size();
        repeat (40) @(negedge clk);
        check_val("rst_dump quiet", 96'(tx_q.size() - n), 96'd0);
        wb = wr_addr_q.size();
        load_halt_only();
        check_val("rst_dump reload", 96'(wr_addr_q.size() - wb), 96'd1);
        if (wr_addr_q.size() > wb) check_val("rst_dump addr", 96'(wr_addr_q[wb]), 96'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side controller for the pipelined MIPS datapath. It exchanges bytes with a UART RX/TX pair and loads program words into instruction memory.
- It gates the datapath `enable` for RUN and STEP execution, then serialises processor state back to the host: cycle count, PC, register file and data memory.
- It drives the datapath debug inputs (instruction-memory write port, data-memory debug read port) and consumes the datapath debug outputs.

Parameters:
- PC_BITS, 32, program counter width
- INSTRUCTION_BITS, 32, instruction word width
- PROC_BITS, 32, register/data word width
- DATA_ADDRS_BITS, 7, data memory address width
- N_REGS, 32, register file entries
- DUMP_MEM_WORDS, 32, data words returned per dump (≤ 2^DATA_ADDRS_BITS)
- HALT_WORD, 32'hFFFF_FFFF, instruction that terminates LOAD and marks program end

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_rx_data  in  8  received byte
- i_rx_done  in  1  one-cycle pulse: i_rx_data valid
- i_tx_done  in  1  one-cycle pulse: UART TX finished current byte
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse: start transmission of o_tx_data
- i_halt  in  1  level: HALT_WORD has reached WB
- i_pc  in  PC_BITS  current IF/ID PCNext
- i_rf_regs  in  N_REGS*PROC_BITS  register file; reg k at [k*PROC_BITS +: PROC_BITS]
- i_mem_data  in  PROC_BITS  data memory debug read result (valid 1 cycle after address)
- o_enable  out  1  datapath clock enable
- o_write_inst_mem  out  1  instruction memory write strobe
- o_inst_mem_addr  out  PC_BITS  instruction memory word address
- o_inst_mem_data  out  INSTRUCTION_BITS  instruction word
- o_debug_read_data  out  1  data memory debug read select
- o_debug_read_address  out  DATA_ADDRS_BITS  data memory debug address

Behaviour:
- Reset: all outputs 0; state IDLE; load address, byte counters and cycle counter 0. Reset during any state aborts the operation in the same cycle; no partial word is written.
- Commands are accepted only in IDLE, one byte per i_rx_done:
  - 'L' (8'h4C): LOAD.
  - 'R' (8'h52): RUN.
  - 'S' (8'h53): STEP.
  - Any other byte is discarded; state stays IDLE.
- LOAD:
  - Clears the load address and cycle counter.
  - Assembles each 4-byte word MSB first.
  - On the 4th byte, the next cycle drives o_write_inst_mem=1 for exactly one cycle, with the current address and word on o_inst_mem_addr/o_inst_mem_data. The address then increments by 1, wrapping at 2^PC_BITS.
  - If the written word equals HALT_WORD, return to IDLE after the write; the HALT word itself is written. No reply byte is sent.
  - i_rx_done during the write cycle is still captured as byte 0 of the next word.
- RUN: o_enable=1 every cycle until i_halt is sampled high. o_enable drops in the cycle after i_halt, then DUMP starts. If i_halt is already high on entry, o_enable is never asserted and DUMP follows immediately.
- STEP: o_enable=1 for exactly one cycle, then DUMP. No step is taken if i_halt is already high; DUMP only.
- Cycle counter: PROC_BITS wide, +1 on every cycle with o_enable=1, wraps.
- DUMP order, every word MSB first:
  1. cycle count, 4 bytes
  2. i_pc, 4 bytes
  3. reg 0..N_REGS-1, 4 bytes each
  4. data words 0..DUMP_MEM_WORDS-1, 4 bytes each
  - Total bytes = 8 + 4*N_REGS + 4*DUMP_MEM_WORDS (264 with defaults).
  - i_pc and i_rf_regs are sampled when their word is first sent; o_enable is 0 throughout DUMP, so they are stable.
  - Memory word k: drive o_debug_read_data=1 with o_debug_read_address=k, wait one cycle, capture i_mem_data, then send. o_debug_read_data returns to 0 when DUMP ends.
- TX handshake:
  - o_tx_data is set with o_tx_start=1 for one cycle.
  - The unit waits for i_tx_done before the next o_tx_start; at most one byte is outstanding.
  - i_tx_done arriving while nothing is outstanding is ignored.
- After the last i_tx_done of a dump, return to IDLE. RX bytes received during RUN, STEP or DUMP are dropped.
- States:
  - IDLE → LOAD_RX → LOAD_WR → LOAD_RX | IDLE
  - IDLE → RUN → DUMP_LOAD
  - IDLE → STEP → DUMP_LOAD
  - DUMP_LOAD → MEM_WAIT (memory section only) → TX_START → TX_WAIT → DUMP_LOAD | IDLE

Decomposition:
- Shared constants header: command codes (CMD_LOAD, CMD_RUN, CMD_STEP), HALT_WORD, dump section sizes, state encodings.
- Sub-module `debug_tx_serializer`: takes a PROC_BITS word with a start strobe, emits 4 bytes MSB first over the tx_start/tx_done handshake, and returns a done pulse. The FSM in debug_unit owns sequencing and addressing.

Test Plan:
- LOAD: 'L', 00 00 00 01, 12 34 56 78, FF FF FF FF → three single-cycle writes at addr 0,1,2 with data 0x00000001, 0x12345678, 0xFFFFFFFF; then IDLE; o_tx_start never pulses.
- STEP after load, TB i_pc=4, reg3=0xA5, mem word 2=0xDEAD_BEEF → o_enable high exactly 1 cycle; 264 bytes sent.
  - Bytes 0-3 = 00 00 00 01; bytes 4-7 = 00 00 00 04.
  - Reg3 bytes = 00 00 00 A5; mem word 2 bytes = DE AD BE EF.
- RUN, i_halt raised after 10 enable cycles → o_enable high 10 cycles; dump cycle count = 0x0000000A; no o_tx_start before the previous i_tx_done.
- Unknown byte 0x00 in IDLE, then 'S' → 0x00 ignored; STEP executes normally.
- rst asserted mid-LOAD after 2 bytes of a word, and separately mid-DUMP → next cycle all outputs 0 and IDLE; subsequent 'L' restarts at address 0.
- i_halt high before 'R' → o_enable never asserted; dump starts immediately with cycle count unchanged.
